// File: rtl/dconv2d_stream.sv
// Streaming 3x3 dilated convolution over a raster-order pixel stream.
// Eight circular row buffers plus a short column history per window row
// build the dilated window. Three pipeline stages follow each accepted
// pixel: tap capture, nine multiplies, then adder tree and optional ReLU.
//
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid and ready are both high. out_valid/out_data stay stable while
// out_valid & ~out_ready, and during that hold the whole pipeline (and the
// input port) is frozen.
module dconv2d_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int MAX_W  = 256,
  parameter int MAX_H  = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(MAX_W+1)-1:0]     cfg_width,
  input  logic [$clog2(MAX_H+1)-1:0]     cfg_height,
  input  logic [1:0]                     cfg_dil,
  input  logic                           cfg_stride2,
  input  logic                           cfg_relu,
  input  logic [9*DATA_W-1:0]            filter_i,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_W-1:0]       in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC_W-1:0]        out_data,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err,
  output logic [1:0]                     dbg_state
);

  localparam int WW = $clog2(MAX_W+1);
  localparam int HW = $clog2(MAX_H+1);
  localparam int XW = $clog2(MAX_W);
  localparam int PW = 2*DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state;

  // Latched frame configuration
  logic [WW-1:0]             w_q;
  logic [HW-1:0]             h_q;
  logic [2:0]                dd_q;
  logic                      stride2_q;
  logic                      relu_q;
  logic signed [DATA_W-1:0]  tap_q [0:8];

  // Raster position of the next pixel to be accepted
  logic [WW-1:0] col;
  logic [HW-1:0] row;

  // Pipeline valid flags
  logic v1, v2;

  logic adv, accept;
  logic [3:0] new_d;
  logic cfg_ok;
  logic [3:0] two_d;
  logic last_col, last_row, win_ok;
  logic [2:0] slot_cur, slot_d, slot_2d;
  logic [XW-1:0] col_idx;

  logic signed [DATA_W-1:0] row_mem [0:7][0:MAX_W-1];
  logic signed [DATA_W-1:0] hist_a [0:8];   // row r-2d
  logic signed [DATA_W-1:0] hist_b [0:8];   // row r-d
  logic signed [DATA_W-1:0] hist_c [0:8];   // row r
  logic signed [DATA_W-1:0] win    [0:8];
  logic signed [PW-1:0]     prod_d [0:8];
  logic signed [PW-1:0]     prod_q [0:8];
  logic signed [ACC_W-1:0]  sum_d;

  assign adv       = ~(out_valid & ~out_ready);
  assign in_ready  = (state == S_RUN) & adv;
  assign accept    = in_valid & in_ready;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  assign two_d    = {dd_q, 1'b0};
  assign slot_cur = row[2:0];
  assign slot_d   = row[2:0] - dd_q;
  assign slot_2d  = row[2:0] - two_d[2:0];
  assign col_idx  = col[XW-1:0];

  assign last_col = (col == w_q - WW'(1));
  assign last_row = (row == h_q - HW'(1));
  assign win_ok   = (row >= HW'(two_d)) && (col >= WW'(two_d)) &&
                    (~stride2_q || (~row[0] && ~col[0]));

  // Validate the incoming configuration against dilation and size limits
  always_comb begin
    new_d  = 4'd1 << cfg_dil;
    cfg_ok = (cfg_dil != 2'd3) &&
             (int'(cfg_width)  >= 2*int'(new_d) + 1) &&
             (int'(cfg_height) >= 2*int'(new_d) + 1) &&
             (int'(cfg_width)  <= MAX_W) &&
             (int'(cfg_height) <= MAX_H);
  end

  // Frame control: config latch, raster counters, done/cfg_err pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      w_q       <= '0;
      h_q       <= '0;
      dd_q      <= 3'd1;
      stride2_q <= 1'b0;
      relu_q    <= 1'b0;
      for (int i = 0; i < 9; i++) tap_q[i] <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              w_q       <= cfg_width;
              h_q       <= cfg_height;
              dd_q      <= new_d[2:0];
              stride2_q <= cfg_stride2;
              relu_q    <= cfg_relu;
              for (int i = 0; i < 9; i++)
                tap_q[i] <= $signed(filter_i[i*DATA_W +: DATA_W]);
              row   <= '0;
              col   <= '0;
              state <= S_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row   <= '0;
                state <= S_DRAIN;
              end else begin
                row <= row + HW'(1);
              end
            end else begin
              col <= col + WW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!v1 && !v2 && (!out_valid || out_ready)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Row storage: the current pixel overwrites the slot of row r-8
  always_ff @(posedge clk) begin
    if (accept) row_mem[slot_cur][col_idx] <= in_data;
  end

  // Column histories; slot_2d is read before the same-cycle write when d=4
  always_ff @(posedge clk) begin
    if (accept) begin
      hist_a[0] <= row_mem[slot_2d][col_idx];
      hist_b[0] <= row_mem[slot_d][col_idx];
      hist_c[0] <= in_data;
      for (int i = 1; i < 9; i++) begin
        hist_a[i] <= hist_a[i-1];
        hist_b[i] <= hist_b[i-1];
        hist_c[i] <= hist_c[i-1];
      end
    end
  end

  // Pick the dilated window out of the histories and form the products
  always_comb begin
    win[0] = hist_a[two_d];
    win[1] = hist_a[{1'b0, dd_q}];
    win[2] = hist_a[0];
    win[3] = hist_b[two_d];
    win[4] = hist_b[{1'b0, dd_q}];
    win[5] = hist_b[0];
    win[6] = hist_c[two_d];
    win[7] = hist_c[{1'b0, dd_q}];
    win[8] = hist_c[0];
    for (int i = 0; i < 9; i++) prod_d[i] = win[i] * tap_q[i];
  end

  // Adder tree over sign-extended products
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++) sum_d = sum_d + ACC_W'(prod_q[i]);
  end

  // Product register, advanced only when the pipeline moves
  always_ff @(posedge clk) begin
    if (adv && v1) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
    end
  end

  // Valid pipeline and output register with ReLU
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      v1        <= accept & win_ok;
      v2        <= v1;
      out_valid <= v2;
      if (v2) out_data <= (relu_q && sum_d[ACC_W-1]) ? '0 : sum_d;
    end
  end

endmodule

// File: tb/tb_dconv2d_stream.sv
// Directed bench for dconv2d_stream: small frames with hand-computed results,
// a randomized-backpressure frame against a behavioural model, config errors
// and a mid-frame reset.
module tb_dconv2d_stream;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int MAX_W  = 256;
  localparam int MAX_H  = 256;
  localparam int WW     = $clog2(MAX_W+1);
  localparam int HW     = $clog2(MAX_H+1);

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [WW-1:0]             cfg_width;
  logic [HW-1:0]             cfg_height;
  logic [1:0]                cfg_dil;
  logic                      cfg_stride2;
  logic                      cfg_relu;
  logic [9*DATA_W-1:0]       filter_i;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DATA_W-1:0]  in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [ACC_W-1:0]   out_data;
  logic                      busy;
  logic                      done;
  logic                      cfg_err;
  logic [1:0]                dbg_state;

  dconv2d_stream #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_W(MAX_W), .MAX_H(MAX_H)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_dil(cfg_dil),
    .cfg_stride2(cfg_stride2), .cfg_relu(cfg_relu), .filter_i(filter_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic signed [DATA_W-1:0] img  [0:255];
  logic signed [DATA_W-1:0] tapv [0:8];
  logic [ACC_W-1:0] exp_q [$];
  logic [ACC_W-1:0] got_q [$];
  int acc_cyc [$];
  int first_valid_cyc, last_hs_cyc, done_cyc, done_cnt, stab_err;
  bit rnd_ready;

  // ---------------- driver tasks ----------------
  task automatic do_start(input int w, input int h, input int dcode,
                          input bit s2, input bit relu);
    @(negedge clk);
    for (int i = 0; i < 9; i++) filter_i[i*DATA_W +: DATA_W] = tapv[i];
    cfg_width   = WW'(w);
    cfg_height  = HW'(h);
    cfg_dil     = 2'(dcode);
    cfg_stride2 = s2;
    cfg_relu    = relu;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      int tmo;
      tmo      = 0;
      in_valid = 1'b1;
      in_data  = img[i];
      while (!in_ready && tmo < 500) begin
        @(negedge clk);
        tmo++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL send_timeout pixel %0d: in_ready 0, required 1", i);
        in_valid = 1'b0;
        return;
      end
      acc_cyc.push_back(cyc);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int budget);
    bit hold_v;
    logic [ACC_W-1:0] hold_d;
    int tail;
    got_q.delete();
    done_cnt = 0; stab_err = 0; tail = 0; hold_v = 0; hold_d = '0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (hold_v && out_data !== hold_d) stab_err++;
        if (out_ready) begin
          got_q.push_back(out_data);
          last_hs_cyc = cyc;
          hold_v = 0;
        end else begin
          hold_v = 1;
          hold_d = out_data;
        end
      end else begin
        if (hold_v) stab_err++;
        hold_v = 0;
      end
      if (done_cnt > 0) begin
        tail++;
        if (tail > 3) break;
      end
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    out_ready = 1'b1;
  endtask

  task automatic run_frame(input int w, input int h, input int dcode,
                           input bit s2, input bit relu, input bit rnd);
    rnd_ready = rnd;
    out_ready = 1'b1;
    acc_cyc.delete();
    do_start(w, h, dcode, s2, relu);
    fork
      send_pixels(w*h);
      collect(3000);
    join
  endtask

  // Behavioural reference: direct evaluation of every kept window position
  task automatic build_model(input int w, input int h, input int d,
                             input int s, input bit relu);
    exp_q.delete();
    for (int r = 2*d; r < h; r += s) begin
      for (int c = 2*d; c < w; c += s) begin
        int sum;
        sum = 0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            sum += int'(tapv[3*kr+kc]) *
                   int'(img[(r-2*d+kr*d)*w + (c-2*d+kc*d)]);
        if (relu && sum < 0) sum = 0;
        exp_q.push_back(ACC_W'(sum));
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'sd3;
    out_ready = 1'b1; cfg_width = '0; cfg_height = '0; cfg_dil = '0;
    cfg_stride2 = 1'b0; cfg_relu = 1'b0; filter_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b, required 0", cfg_err); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    in_valid = 1'b0;
  endtask

  task automatic test_ones();
    for (int i = 0; i < 25; i++) img[i] = 8'sd1;
    for (int i = 0; i < 9; i++) tapv[i] = 8'sd1;
    run_frame(5, 5, 0, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(ACC_W'(9));
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ones_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ones_out[%0d]: got %0d, required %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ones_done_count: got %0d, required 1", done_cnt); end
    checks++; if (done_cyc != last_hs_cyc + 1) begin errors++; $display("FAIL ones_done_timing: got cycle %0d, required %0d", done_cyc, last_hs_cyc + 1); end
    if (acc_cyc.size() > 12) begin
      checks++; if (first_valid_cyc - acc_cyc[12] != 3) begin errors++; $display("FAIL ones_latency: got %0d, required 3", first_valid_cyc - acc_cyc[12]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ones_busy_after: got %b, required 0", busy); end
  endtask

  task automatic test_dil2();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) img[5*r+c] = DATA_W'(5*r+c);
    for (int i = 0; i < 9; i++) tapv[i] = DATA_W'(i);
    run_frame(5, 5, 1, 1'b0, 1'b0, 1'b0);
    // rows 0,2,4 x cols 0,2,4 -> 0*0+1*2+2*4 + 3*10+4*12+5*14 + 6*20+7*22+8*24
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL dil2_count: got %0d, required 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== ACC_W'(624)) begin errors++; $display("FAIL dil2_out: got %0d, required 624", $signed(got_q[0])); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL dil2_done_count: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_stride2();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) img[7*r+c] = DATA_W'(7*r+c);
    for (int i = 0; i < 9; i++) tapv[i] = (i == 4) ? 8'sd1 : 8'sd0;
    run_frame(7, 7, 0, 1'b1, 1'b0, 1'b0);
    exp_q.delete();
    exp_q = '{32'd8, 32'd10, 32'd12, 32'd22, 32'd24, 32'd26, 32'd36, 32'd38, 32'd40};
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stride2_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stride2_out[%0d]: got %0d, required %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stride2_done_count: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_relu();
    for (int i = 0; i < 16; i++) img[i] = -8'sd1;
    for (int i = 0; i < 9; i++) tapv[i] = 8'sd1;
    for (int pass = 0; pass < 2; pass++) begin
      logic [ACC_W-1:0] want;
      want = (pass == 0) ? ACC_W'(0) : ACC_W'(-9);
      run_frame(4, 4, 0, 1'b0, (pass == 0), 1'b0);
      checks++; if (got_q.size() != 4) begin errors++; $display("FAIL relu%0d_count: got %0d, required 4", pass, got_q.size()); end
      for (int i = 0; i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== want) begin errors++; $display("FAIL relu%0d_out[%0d]: got %0d, required %0d", pass, i, $signed(got_q[i]), $signed(want)); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL relu%0d_done_count: got %0d, required 1", pass, done_cnt); end
    end
  endtask

  task automatic test_random_stall();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 144; i++) img[i] = DATA_W'($urandom_range(0, 255));
      for (int i = 0; i < 9; i++) tapv[i] = DATA_W'($urandom_range(0, 255));
      build_model(16, 9, 4, (pass == 0) ? 1 : 2, (pass == 1));
      run_frame(16, 9, 2, (pass == 1), (pass == 1), 1'b1);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d, required %0d", pass, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_out[%0d]: got %0d, required %0d", pass, i, $signed(got_q[i]), $signed(exp_q[i])); end
      end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL rand%0d_hold_stable: got %0d changes, required 0", pass, stab_err); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand%0d_done_count: got %0d, required 1", pass, done_cnt); end
    end
  endtask

  task automatic test_cfg_err();
    int tw [0:3];
    int th [0:3];
    int td [0:3];
    tw = '{5, 4, 257, 5};
    th = '{5, 9, 5, 2};
    td = '{3, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      do_start(tw[k], th[k], td[k], 1'b0, 1'b0);
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err%0d_pulse: got %b, required 1", k, cfg_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_err%0d_busy: got %b, required 0", k, busy); end
      @(negedge clk);
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err%0d_width: got %b, required 0", k, cfg_err); end
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 25; i++) img[i] = 8'sd7;
    for (int i = 0; i < 9; i++) tapv[i] = 8'sd1;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    do_start(5, 5, 0, 1'b0, 1'b0);
    send_pixels(12);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b, required 1", busy); end
    // reset with a coincident (valid) start that must be ignored
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b, required 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b, required 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b, required 0", done); end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) img[5*r+c] = DATA_W'(r+c);
    run_frame(5, 5, 0, 1'b0, 1'b0, 1'b0);
    // window sum of (i+j) = 9*(r+c) - 18
    exp_q.delete();
    exp_q = '{32'd18, 32'd27, 32'd36, 32'd27, 32'd36, 32'd45, 32'd36, 32'd45, 32'd54};
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_out[%0d]: got %0d, required %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_done_count: got %0d, required 1", done_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ones();
    test_dil2();
    test_stride2();
    test_relu();
    test_random_stall();
    test_cfg_err();
    test_abort();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
